reg_file_multiport: RTL and testbench
=====================================

Name: reg_file_multiport

Overview:
Parametrised general-purpose register file for the RV32I datapath, and the successor to the single-port register bank. It provides NUM_RD independent combinational read ports and one synchronous write port. Register 0 is hardwired to zero, with optional write-to-read bypass. A sequenced bulk-clear engine zeroes the whole array one entry per cycle on request, for context flush and debug reset.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads see stored value only
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write request, sampled at posedge clk
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port p uses bits [p*DATA_W +: DATA_W]; combinational
clr_req  in  1  bulk-clear request, sampled in IDLE only
clr_busy  out  1  high while the clear sequence runs; writes are dropped
clr_done  out  1  one-cycle pulse when the clear sequence completes

Behaviour:
- Reset (asynchronous assert, any cycle):
  - all DEPTH entries go to 0
  - FSM goes to IDLE, clear counter goes to 0
  - clr_busy = 0, clr_done = 0
  - rd_data = 0 for every port while reset is held
- Write path:
  - On posedge clk, if wr_en && !clr_busy, then mem[wr_addr] <= wr_data.
  - When ZERO_REG=1, a write to address 0 is discarded.
  - Writes while clr_busy=1 are silently dropped. There is no stall; the upstream pipeline must honour clr_busy.
- Read path (per port, combinational, no clock latency):
  - If ZERO_REG && addr==0: rd_data = 0.
  - Else if BYPASS && wr_en && !clr_busy && wr_addr==addr: rd_data = wr_data.
  - Else: rd_data = mem[addr].
  - All ports are independent. Any number of ports may read the same address in the same cycle.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE:
    - clr_req=1 -> CLEAR, counter <= 0.
    - Otherwise stay in IDLE.
  - CLEAR:
    - clr_busy=1 and mem[counter] <= 0 each cycle, then counter++.
    - When counter == DEPTH-1 and that entry is cleared -> DONE.
    - Occupancy is exactly DEPTH cycles (32 with defaults).
    - clr_req is ignored during CLEAR.
  - DONE:
    - clr_done=1 and clr_busy=0 for exactly one cycle, then -> IDLE.
    - clr_req is ignored in DONE; it is re-sampled from the following IDLE cycle.
- Reads during CLEAR return the current array contents: already-cleared entries read 0, not-yet-cleared entries read their old value. Bypass is suppressed during CLEAR.
- Reset asserted mid-CLEAR: the sequence aborts, the array is zero anyway, and the FSM is in IDLE on release. No clr_done is produced.
- Counter is ADDR_W bits wide. It must not wrap to re-clear entry 0; the exit condition is the DEPTH-1 compare.
- Write-address and read-address widths are exact; no out-of-range case exists.
- Registered outputs: clr_busy and clr_done are decoded from FSM state registers and are glitch-free.

Test Plan:
1. Reset then read all 32 addresses on both ports -> every rd_data = 0x00000000; clr_busy=0, clr_done=0.
2. Write 0xDEADBEEF to x5, then 0x12345678 to x0; read x5 on port 0 and x0 on port 1 -> port 0 = 0xDEADBEEF, port 1 = 0x00000000.
3. With BYPASS=1, drive wr_en=1, wr_addr=7, wr_data=0xCAFEF00D, and both rd_addr=7 in the same cycle -> both ports show 0xCAFEF00D before the edge. Repeat with BYPASS=0 -> both show the old x7 value (0) until after the edge.
4. Fill x1..x31 with value = addr*0x01010101 and pulse clr_req:
   - clr_busy high exactly 32 cycles
   - mid-sequence at cycle 10, reading x3 gives 0 and x20 gives 0x14141414
   - a wr_en to x20 during busy is dropped
   - clr_done pulses 1 cycle later
   - afterwards all reads = 0
5. Start a clear, assert reset at cycle 12 of CLEAR -> clr_busy drops asynchronously and no clr_done appears. After release, clr_req restarts a full 32-cycle sequence.
6. ZERO_REG=0, NUM_RD=3 instance: write 0xA5A5A5A5 to x0 and read x0 on all three ports -> all three = 0xA5A5A5A5.

Source files
------------

// File: rtl/reg_file_multiport.sv
// reg_file_multiport
// General-purpose register file for the RV32I datapath. It has NUM_RD
// independent combinational read ports and one synchronous write port.
// Entry 0 is optionally hardwired to zero, and write-to-read forwarding is
// optional. A bulk-clear engine zeroes the array one entry per cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   wr_en     write request, sampled at posedge clk
//   wr_addr   write address
//   wr_data   write data
//   rd_addr   packed read addresses; port p uses [p*ADDR_W +: ADDR_W]
//   rd_data   packed read data; port p uses [p*DATA_W +: DATA_W] (combinational)
//   clr_req   bulk-clear request, sampled in IDLE only
//   clr_busy  high while the clear sequence runs; writes are dropped
//   clr_done  one-cycle pulse when the clear sequence completes
module reg_file_multiport #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                wr_ok_s;

  // A write only takes effect outside CLEAR and, with ZERO_REG, never to entry 0.
  assign wr_ok_s = wr_en && (state_q != ST_CLEAR);

  // Clear-FSM next state; busy/done are precomputed from the next state so
  // the outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = ADDR_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Exit on the last index rather than letting the counter wrap.
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          cnt_d   = ADDR_ZERO;
        end else begin
          cnt_d = cnt_q + ADDR_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ADDR_ZERO;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
    done_d = (state_d == ST_DONE);
  end

  // Clear-FSM state, counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= ADDR_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;

  // Next array contents: the clear engine owns the array while in CLEAR.
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[cnt_q] = '0;
    end else if (wr_ok_s && !((ZERO_REG != 0) && (wr_addr == ADDR_ZERO))) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read ports. Reset forces zero so a forwarded write cannot
  // leak out while reset is held.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (reset) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_ZERO)) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && wr_ok_s && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
        rd_data[p*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = mem_q[rd_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Self-checking bench for reg_file_multiport. Three instances share the write
// and control inputs: the default build, a BYPASS=0 build and a
// ZERO_REG=0 / NUM_RD=3 build. Stimulus pushes expected values into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_reg_file_multiport;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;

  logic [9:0]  rd_addr_a, rd_addr_b;
  logic [14:0] rd_addr_c;
  logic [63:0] rd_data_a, rd_data_b;
  logic [95:0] rd_data_c;
  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;

  int checks;
  int failures;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_multiport dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .clr_req(clr_req),
    .clr_busy(busy_a), .clr_done(done_a)
  );

  reg_file_multiport #(.BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .clr_req(clr_req),
    .clr_busy(busy_b), .clr_done(done_b)
  );

  reg_file_multiport #(.ZERO_REG(0), .NUM_RD(3)) dut_c (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c), .clr_req(clr_req),
    .clr_busy(busy_c), .clr_done(done_c)
  );

  // sel: 0/1 dut_a ports, 2/3 dut_b ports, 4..6 dut_c ports, 7 busy_a, 8 done_a
  function automatic logic [31:0] get_act(input int sel);
    case (sel)
      0: return rd_data_a[31:0];
      1: return rd_data_a[63:32];
      2: return rd_data_b[31:0];
      3: return rd_data_b[63:32];
      4: return rd_data_c[31:0];
      5: return rd_data_c[63:32];
      6: return rd_data_c[95:64];
      7: return {31'd0, busy_a};
      8: return {31'd0, done_a};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic expect_status(input logic busy, input logic done, input string name);
    expect_val(7, {31'd0, busy}, {name, "_busy"});
    expect_val(8, {31'd0, done}, {name, "_done"});
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational/registered, so the falling edge is a
  // stable point to compare everything queued during the current cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = get_act(e.sel);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    logic [31:0] v;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'd0;
    clr_req = 1'b0;
    rd_addr_a = 10'd0;
    rd_addr_b = 10'd0;
    rd_addr_c = 15'd0;

    // Test 1: reads during and after reset are zero
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1111_1111;
    rd_addr_a = {5'd3, 5'd3};
    expect_val(0, 32'h0, "t1_reset_bypass_p0");
    expect_val(1, 32'h0, "t1_reset_bypass_p1");
    expect_status(1'b0, 1'b0, "t1_reset");
    step();
    wr_en = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = {5'(31 - i), 5'(i)};
      expect_val(0, 32'h0, "t1_rd_p0");
      expect_val(1, 32'h0, "t1_rd_p1");
      if (i == 0) expect_status(1'b0, 1'b0, "t1_idle");
      step();
    end

    // Test 2: ordinary write and discarded write to x0
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    step();
    wr_addr = 5'd0; wr_data = 32'h1234_5678;
    step();
    wr_en = 1'b0;
    rd_addr_a = {5'd0, 5'd5};
    expect_val(0, 32'hDEAD_BEEF, "t2_x5");
    expect_val(1, 32'h0, "t2_x0_zero");
    step();

    // Test 3: same-cycle forwarding vs stored-only reads
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFE_F00D;
    rd_addr_a = {5'd7, 5'd7};
    rd_addr_b = {5'd7, 5'd7};
    expect_val(0, 32'hCAFE_F00D, "t3_byp_p0");
    expect_val(1, 32'hCAFE_F00D, "t3_byp_p1");
    expect_val(2, 32'h0, "t3_nobyp_p0");
    expect_val(3, 32'h0, "t3_nobyp_p1");
    step();
    wr_en = 1'b0;
    expect_val(2, 32'hCAFE_F00D, "t3_nobyp_after_p0");
    expect_val(3, 32'hCAFE_F00D, "t3_nobyp_after_p1");
    step();

    // Test 4: fill x1..x31 then bulk clear
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h0101_0101;
      step();
    end
    wr_en = 1'b0;
    rd_addr_a = {5'd31, 5'd20};
    expect_val(0, 32'h1414_1414, "t4_fill_x20");
    expect_val(1, 32'h1F1F_1F1F, "t4_fill_x31");
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      expect_status(1'b1, 1'b0, "t4_clear");
      if (c == 10) begin
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFF_FFFF;
        rd_addr_a = {5'd20, 5'd3};
        rd_addr_b = {5'd31, 5'd31};
        expect_val(0, 32'h0, "t4_mid_x3");
        expect_val(1, 32'h1414_1414, "t4_mid_x20");
      end else if (c == 11) begin
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hFFFF_FFFF;
        rd_addr_a = {5'd20, 5'd20};
        expect_val(0, 32'h1414_1414, "t4_nobyp_busy_x20");
      end else if (c == 32) begin
        rd_addr_a = {5'd30, 5'd31};
        expect_val(0, 32'h1F1F_1F1F, "t4_drop_x31");
        expect_val(1, 32'h0, "t4_x30_cleared");
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    expect_status(1'b0, 1'b1, "t4_done");
    step();
    expect_status(1'b0, 1'b0, "t4_after");
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = {5'(31 - i), 5'(i)};
      expect_val(0, 32'h0, "t4_post_p0");
      expect_val(1, 32'h0, "t4_post_p1");
      step();
    end

    // Test 6: ZERO_REG=0, three ports all read a written x0
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hA5A5_A5A5;
    step();
    wr_en = 1'b0;
    rd_addr_c = 15'd0;
    rd_addr_a = 10'd0;
    expect_val(4, 32'hA5A5_A5A5, "t6_x0_p0");
    expect_val(5, 32'hA5A5_A5A5, "t6_x0_p1");
    expect_val(6, 32'hA5A5_A5A5, "t6_x0_p2");
    expect_val(0, 32'h0, "t6_zreg_x0");
    step();

    // Test 5: reset in the middle of a clear
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h9999_9999;
    step();
    wr_en = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 1; c < 12; c++) begin
      expect_status(1'b1, 1'b0, "t5_clear");
      step();
    end
    rd_addr_a = {5'd25, 5'd25};
    expect_val(0, 32'h9999_9999, "t5_x25_before");
    step();
    reset = 1'b1;
    expect_status(1'b0, 1'b0, "t5_async");
    expect_val(1, 32'h0, "t5_x25_reset");
    step();
    expect_status(1'b0, 1'b0, "t5_held");
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      expect_status(1'b0, 1'b0, "t5_released");
      step();
    end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      expect_status(1'b1, 1'b0, "t5_reclear");
      step();
    end
    expect_status(1'b0, 1'b1, "t5_done");
    step();
    expect_status(1'b0, 1'b0, "t5_idle");
    step();
    step();

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    v = 32'(checks);
    $display("TB_RESULT checks=%0d failures=%0d", v, failures);
    $finish;
  end

endmodule
